regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file for the pipelined core; successor to the
//   single-write/dual-read register file. Adds configurable width, depth and read-port count,
//   a second write port, optional write-to-read bypass, and a per-register busy scoreboard
//   used by decode to detect RAW hazards on in-flight destinations.
// PARAMETERS
//   XLEN    32              data width per register
//   NREGS   32              number of registers (power of 2, >=2); register 0 hardwired to zero
//   AW      $clog2(NREGS)   register address width (derived, do not override)
//   NRD     2               number of read ports (1..4)
//   BYPASS  1               1: same-cycle write data forwarded to reads; 0: read-before-write
// PORTS
//   clk         in   1          clock, all state updates on rising edge
//   rst         in   1          one clock; reset is synchronous and active-low
//   we0         in   1          write enable, port 0
//   wa0         in   AW         write address, port 0
//   wd0         in   XLEN       write data, port 0
//   we1         in   1          write enable, port 1 (priority over port 0)
//   wa1         in   AW         write address, port 1
//   wd1         in   XLEN       write data, port 1
//   ra          in   NRD*AW     read addresses, port i at [i*AW +: AW]
//   rdata       out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
//   alloc_en    in   1          mark alloc_addr busy (destination issued)
//   alloc_addr  in   AW         register being allocated
//   busy        out  NREGS      scoreboard, bit r = 1 while register r has a pending write
//   rd_busy     out  NRD        busy flag of each read port's address, bypass-adjusted
// BEHAVIOUR
//   - Reset (rst==0 at rising edge): all registers <= 0, all busy bits <= 0; we0/we1/alloc_en
//     ignored that cycle. After reset, all rdata = 0, busy = 0, rd_busy = 0.
//   - Write: at rising edge with rst==1, weN && waN!=0 -> reg[waN] <= wdN. Both ports same
//     address: port 1 value stored. Writes to address 0 discarded; reg[0] reads 0 always.
//   - Read: combinational, zero latency. ra_i==0 -> rdata_i = 0 regardless of writes/bypass.
//     BYPASS=1: if we1 && wa1==ra_i -> wd1; else if we0 && wa0==ra_i -> wd0; else reg[ra_i].
//     BYPASS=0: rdata_i = reg[ra_i] (old value in the write cycle, new value next cycle).
//   - Scoreboard, at rising edge with rst==1, per register r!=0:
//     set   = alloc_en && alloc_addr==r
//     clear = (we0 && wa0==r) || (we1 && wa1==r)
//     set wins over clear (new producer issued same cycle old producer writes back).
//     busy[0] is constant 0; alloc to address 0 ignored.
//   - rd_busy_i = busy[ra_i] && !(BYPASS && (clear condition for ra_i this cycle)); 0 for ra_i==0.
//     Combinational; does not reflect a same-cycle alloc (visible next cycle via busy).
//   - Write to a non-busy register is legal: data stored, busy stays 0.
//   - Out-of-range addresses impossible (NREGS is power of 2); no error outputs.
//   - Reset asserted mid-operation: clears same edge; pending allocs lost (busy -> 0).
// TESTING
//   1 reset: rst=0 one cycle with we0=1,wa0=5,wd0=0xDEADBEEF -> after edge ra0=5 gives 0, busy=0.
//   2 write/read: we0=1,wa0=8,wd0=123; next cycle ra0=8 -> rdata0=123; ra1=8 same cycle -> 123.
//   3 x0: we1=1,wa1=0,wd1=234234; alloc_en=1,alloc_addr=0 -> rdata for ra=0 stays 0, busy[0]=0.
//   4 dual-write collision: we0=1,wd0=0x11,we1=1,wd1=0x22,wa0=wa1=25 -> BYPASS=1 same-cycle
//     rdata=0x22; next cycle reg[25]=0x22. BYPASS=0: same-cycle rdata = old value.
//   5 scoreboard: alloc 9 -> busy[9]=1, rd_busy for ra=9 =1; writeback we0,wa0=9 -> that cycle
//     rd_busy=0 (BYPASS=1), next cycle busy[9]=0.
//   6 set/clear race: alloc_addr=9 with we0,wa0=9 same edge -> busy[9] remains 1, reg[9]=wd0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with dual write, optional bypass and busy scoreboard
// Register 0 reads zero; write port 1 beats port 0 on the same address.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we0,
   input  logic [AW-1:0]       wa0,
   input  logic [XLEN-1:0]     wd0,
   input  logic                we1,
   input  logic [AW-1:0]       wa1,
   input  logic [XLEN-1:0]     wd1,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rdata,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic [NREGS-1:0]    busy,
   output logic [NRD-1:0]      rd_busy
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_clr;

   // Bit 0 of set/clear stays zero so busy[0] can never rise.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int r = 1; r < NREGS; r++) begin
         w_set[r] = alloc_en && (alloc_addr == AW'(r));
         w_clr[r] = (we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (we0 && (wa0 != '0)) r_regs[wa0] <= wd0;
         if (we1 && (wa1 != '0)) r_regs[wa1] <= wd1;
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign busy = r_busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_rd;

      assign w_ra = ra[i*AW +: AW];

      always_comb begin
         w_rd = r_regs[w_ra];
         if (BYPASS != 0) begin
            if (we0 && (wa0 == w_ra)) w_rd = wd0;
            if (we1 && (wa1 == w_ra)) w_rd = wd1;
         end
         if (w_ra == '0) w_rd = '0;
      end

      assign rdata[i*XLEN +: XLEN] = w_rd;
      // A writeback landing this cycle already satisfies the reader when bypassing.
      assign rd_busy[i] = r_busy[w_ra] && !((BYPASS != 0) && w_clr[w_ra]);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp, bypass and non-bypass instances
// A spec-level array model supplies every expected value.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        we0, we1, alloc_en;
   logic [4:0]  wa0, wa1, alloc_addr;
   logic [31:0] wd0, wd1;
   logic [9:0]  ra;
   logic [63:0] rdata_b1, rdata_b0;
   logic [31:0] busy_b1, busy_b0;
   logic [1:0]  rd_busy_b1, rd_busy_b0;

   logic [31:0] m_reg [32];
   bit          m_busy [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1)) u_b1 (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rdata(rdata_b1),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_b1), .rd_busy(rd_busy_b1)
   );

   regfile_mp #(.BYPASS(0)) u_b0 (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rdata(rdata_b0),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_b0), .rd_busy(rd_busy_b0)
   );

   function automatic logic [31:0] exp_rd(int a, int byp);
      if (a == 0) return 32'h0;
      if (byp != 0 && we1 && int'(wa1) == a) return wd1;
      if (byp != 0 && we0 && int'(wa0) == a) return wd0;
      return m_reg[a];
   endfunction

   function automatic logic exp_rdb(int a, int byp);
      bit wb;
      wb = (we0 && int'(wa0) == a) || (we1 && int'(wa1) == a);
      if (a == 0) return 1'b0;
      return m_busy[a] && !(byp != 0 && wb);
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic idle();
      rst = 1'b1; we0 = 0; we1 = 0; alloc_en = 0;
      wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; alloc_addr = 0; ra = 0;
   endtask

   // Model advances from the inputs present before the edge, then the DUT clocks.
   task automatic step();
      if (!rst) begin
         for (int r = 0; r < 32; r++) begin m_reg[r] = 0; m_busy[r] = 0; end
      end else begin
         for (int r = 1; r < 32; r++) begin
            if ((we0 && int'(wa0) == r) || (we1 && int'(wa1) == r)) m_busy[r] = 0;
            if (alloc_en && int'(alloc_addr) == r) m_busy[r] = 1;
         end
         if (we0 && wa0 != 0) m_reg[wa0] = wd0;
         if (we1 && wa1 != 0) m_reg[wa1] = wd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 0; we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; alloc_en = 1; alloc_addr = 7;
      step();
      idle(); ra = {5'd7, 5'd5}; #1;
      n_tests++; if (rdata_b1 !== 64'h0) begin n_fail++; $display("FAIL reset_rdata_b1 got %h want 0", rdata_b1); end
      n_tests++; if (rdata_b0 !== 64'h0) begin n_fail++; $display("FAIL reset_rdata_b0 got %h want 0", rdata_b0); end
      n_tests++; if (busy_b1 !== 32'h0 || busy_b0 !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h/%h want 0", busy_b1, busy_b0); end
      n_tests++; if (rd_busy_b1 !== 2'b0) begin n_fail++; $display("FAIL reset_rd_busy got %b want 0", rd_busy_b1); end
   endtask

   task automatic test_write_read();
      idle(); we0 = 1; wa0 = 8; wd0 = 123;
      step();
      idle(); ra = {5'd8, 5'd8}; #1;
      n_tests++; if (rdata_b1 !== {32'd123, 32'd123}) begin n_fail++; $display("FAIL wr_rd_b1 got %h want both 123", rdata_b1); end
      n_tests++; if (rdata_b0 !== {32'd123, 32'd123}) begin n_fail++; $display("FAIL wr_rd_b0 got %h want both 123", rdata_b0); end
   endtask

   task automatic test_x0();
      idle(); we1 = 1; wa1 = 0; wd1 = 234234; alloc_en = 1; alloc_addr = 0; ra = 0; #1;
      n_tests++; if (rdata_b1 !== 64'h0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", rdata_b1); end
      step();
      idle(); #1;
      n_tests++; if (rdata_b1 !== 64'h0 || rdata_b0 !== 64'h0) begin n_fail++; $display("FAIL x0_after got %h/%h want 0", rdata_b1, rdata_b0); end
      n_tests++; if (busy_b1[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b want 0", busy_b1[0]); end
   endtask

   task automatic test_collision();
      idle(); we0 = 1; wa0 = 25; wd0 = 32'h55;
      step();
      idle(); we0 = 1; wd0 = 32'h11; we1 = 1; wd1 = 32'h22; wa0 = 25; wa1 = 25; ra = {5'd25, 5'd25}; #1;
      n_tests++; if (rdata_b1[31:0] !== 32'h22) begin n_fail++; $display("FAIL coll_bypass got %h want 22", rdata_b1[31:0]); end
      n_tests++; if (rdata_b0[31:0] !== 32'h55) begin n_fail++; $display("FAIL coll_nobypass got %h want 55", rdata_b0[31:0]); end
      step();
      idle(); ra = {5'd25, 5'd25}; #1;
      n_tests++; if (rdata_b1[63:32] !== 32'h22 || rdata_b0[63:32] !== 32'h22) begin n_fail++; $display("FAIL coll_stored got %h/%h want 22", rdata_b1[63:32], rdata_b0[63:32]); end
   endtask

   task automatic test_scoreboard();
      idle(); alloc_en = 1; alloc_addr = 9;
      step();
      idle(); ra = {5'd0, 5'd9}; #1;
      n_tests++; if (busy_b1[9] !== 1'b1) begin n_fail++; $display("FAIL sb_busy got %b want 1", busy_b1[9]); end
      n_tests++; if (rd_busy_b1 !== 2'b01) begin n_fail++; $display("FAIL sb_rd_busy got %b want 01", rd_busy_b1); end
      we0 = 1; wa0 = 9; wd0 = 77; #1;
      n_tests++; if (rd_busy_b1[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wb_bypass got %b want 0", rd_busy_b1[0]); end
      n_tests++; if (rd_busy_b0[0] !== 1'b1) begin n_fail++; $display("FAIL sb_wb_nobypass got %b want 1", rd_busy_b0[0]); end
      step();
      idle(); #1;
      n_tests++; if (busy_b1[9] !== 1'b0 || busy_b0[9] !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b/%b want 0", busy_b1[9], busy_b0[9]); end
   endtask

   task automatic test_race();
      idle(); alloc_en = 1; alloc_addr = 9;
      step();
      idle(); alloc_en = 1; alloc_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
      step();
      idle(); ra = {5'd9, 5'd9}; #1;
      n_tests++; if (busy_b1[9] !== 1'b1) begin n_fail++; $display("FAIL race_busy got %b want 1", busy_b1[9]); end
      n_tests++; if (rdata_b1[31:0] !== 32'h99) begin n_fail++; $display("FAIL race_data got %h want 99", rdata_b1[31:0]); end
      idle(); rst = 0;
      step();
      idle(); #1;
      n_tests++; if (busy_b1 !== 32'h0) begin n_fail++; $display("FAIL mid_reset_busy got %h want 0", busy_b1); end
   endtask

   task automatic test_random();
      int a0, a1;
      for (int c = 0; c < 400; c++) begin
         idle();
         rst = ($urandom_range(0, 63) != 0);
         we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 2) == 0;
         wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) wa0 = 5'($urandom);
         wd0 = $urandom; wd1 = $urandom;
         alloc_en = $urandom_range(0, 1); alloc_addr = 5'($urandom_range(0, 7));
         a0 = $urandom_range(0, 8); a1 = $urandom_range(0, 31);
         ra = {5'(a1), 5'(a0)};
         #2;
         n_tests++; if (rdata_b1 !== {exp_rd(a1, 1), exp_rd(a0, 1)}) begin n_fail++; $display("FAIL rnd_rdata_b1 c=%0d got %h want %h", c, rdata_b1, {exp_rd(a1, 1), exp_rd(a0, 1)}); end
         n_tests++; if (rdata_b0 !== {exp_rd(a1, 0), exp_rd(a0, 0)}) begin n_fail++; $display("FAIL rnd_rdata_b0 c=%0d got %h want %h", c, rdata_b0, {exp_rd(a1, 0), exp_rd(a0, 0)}); end
         n_tests++; if (rd_busy_b1 !== {exp_rdb(a1, 1), exp_rdb(a0, 1)}) begin n_fail++; $display("FAIL rnd_rd_busy_b1 c=%0d got %b want %b", c, rd_busy_b1, {exp_rdb(a1, 1), exp_rdb(a0, 1)}); end
         n_tests++; if (rd_busy_b0 !== {exp_rdb(a1, 0), exp_rdb(a0, 0)}) begin n_fail++; $display("FAIL rnd_rd_busy_b0 c=%0d got %b want %b", c, rd_busy_b0, {exp_rdb(a1, 0), exp_rdb(a0, 0)}); end
         n_tests++; if (busy_b1 !== exp_busy() || busy_b0 !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy c=%0d got %h/%h want %h", c, busy_b1, busy_b0, exp_busy()); end
         step();
      end
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_write_read();
      test_x0();
      test_collision();
      test_scoreboard();
      test_race();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
